uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single board UART transmitter among NREQ byte producers, e.g. banner/message generator, scan-chain dump and DUT output dump. Each producer presents a byte with valid/last. The arbiter grants round-robin and holds ownership across a packet until the byte marked last is sent. It drives the transmitter with the tx_start/tx_ready handshake already used by the command parser, and adds a stuck-transmitter timeout.

Parameters:
NREQ, 3, number of requesters (2..8)
BUSY_TIMEOUT, 1024, max cycles tx_start_o may stay high waiting for tx_ready_i to fall
TO_WIDTH, 10, counter width; must satisfy 2^TO_WIDTH >= BUSY_TIMEOUT

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous active-high reset, sampled on posedge clk
req_valid_i  in  NREQ  requester i has a byte ready; held with data until req_ack_o[i]
req_data_i  in  8*NREQ  byte of requester i at bits [8i+7:8i]
req_last_i  in  NREQ  byte of requester i ends its packet; releases lock
req_ack_o  out  NREQ  one-cycle pulse: byte of requester i latched
grant_o  out  NREQ  one-hot current owner; 0 when free
tx_start_o  out  1  start request to transmitter
tx_data_o  out  8  byte to transmit, stable while not IDLE
tx_ready_i  in  1  transmitter idle/ready
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse: transmitter failed to accept byte

Behaviour:
- Reset: all outputs are registered and 0 after reset. State IDLE, lock=0, rr pointer=NREQ-1, timeout counter=0. Reset in any state aborts the transfer, and tx_start_o is 0 the cycle after reset is sampled.
- States: IDLE, START, WAIT_DONE.
- IDLE: A winner is chosen when tx_ready_i=1 and a candidate has valid=1.
  - If lock=1, the only candidate is the owner. Others are ignored even if valid.
  - If lock=0, the search starts at ptr+1 with wrap modulo NREQ. The first valid index wins.
  - On a win, at the next edge: tx_data_o<=winner data, last_q<=winner last, grant_o<=onehot(winner), req_ack_o[winner]<=1 for exactly one cycle, tx_start_o<=1, counter<=0, state->START.
  - With no win, grant_o holds the owner while lock=1, otherwise 0.
- START: tx_start_o held 1. Counter increments each cycle.
  - tx_ready_i=0: tx_start_o<=0, state->WAIT_DONE.
  - Else if counter==BUSY_TIMEOUT-1: tx_start_o<=0, timeout_o pulse, lock<=0, grant_o<=0, ptr<=owner, state->IDLE. The byte is dropped and is not re-acked.
  - If tx_ready_i=0 and the timeout hit occur in the same cycle, tx_ready_i=0 wins (no timeout).
- WAIT_DONE: wait for tx_ready_i=1, then state->IDLE.
  - If last_q=1: lock<=0, ptr<=owner, grant_o<=0.
  - Else: lock<=1, grant_o stays the owner.
- Latency: request seen in IDLE -> ack and tx_start_o the next cycle. The minimum cycle between consecutive bytes is IDLE->START->WAIT_DONE->IDLE, plus transmitter busy time.
- Requester rules: after ack, the requester may change data or drop valid the following cycle. A valid that drops before ack is simply not granted; no error.
- A locked owner with valid=0 keeps the lock indefinitely until it sends last or reset occurs. This is intentional, to keep packets atomic.
- tx_start_o never rises while tx_ready_i=0 was the sample in IDLE.
- req_ack_o is at most one-hot. grant_o is always one-hot or zero.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with all valid=1 -> all outputs 0. After release with tx_ready_i=1, req 0 is acked first (ptr starts at NREQ-1).
- Round-robin: valid=3'b111, all last=1, transmitter model busy 10 cycles per byte -> grant order 0,1,2,0,1,2. Each ack is a single-cycle pulse coincident with tx_start_o rising.
- Packet lock: req1 sends 4 bytes 0x41..0x44 with last only on 0x44, while req0/req2 stay valid -> tx_data_o sequence 41,42,43,44 uninterrupted, then grant moves to 2.
- Handshake: transmitter holds tx_ready_i=1 for 5 cycles after start -> tx_start_o stays 1 for those cycles and falls the cycle after tx_ready_i=0. No second start until tx_ready_i returns to 1.
- Timeout: tx_ready_i stuck at 1 with BUSY_TIMEOUT=16 -> timeout_o pulses exactly 16 cycles after tx_start_o rose, tx_start_o=0, lock cleared, next requester served.
- Mid-transfer reset: assert rst in WAIT_DONE during a locked packet -> grant_o, tx_start_o and lock are 0 the next cycle. Arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
// Ownership is held across a packet until its last byte; a stuck transmitter is timed out.
module uart_tx_arbiter #(
  parameter int NREQ         = 3,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int TO_WIDTH     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [8*NREQ-1:0]    req_data_i,
  input  logic [NREQ-1:0]      req_last_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      grant_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_lock, w_lock_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [IW-1:0]       r_owner, w_owner_nxt;
  logic [TO_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                r_last, w_last_nxt;
  logic [NREQ-1:0]     r_ack, w_ack_nxt;
  logic [NREQ-1:0]     r_grant, w_grant_nxt;
  logic                r_tx_start, w_tx_start_nxt;
  logic [7:0]          r_tx_data, w_tx_data_nxt;
  logic                r_busy;
  logic                r_timeout, w_timeout_nxt;

  logic                w_win;
  logic [IW-1:0]       w_win_idx;
  logic                w_go;
  logic                w_cnt_hit;

  function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW:0] f_rr_pick(input logic [NREQ-1:0] vld,
                                            input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    found = 1'b0;
    idx   = ptr;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == IW'(NREQ - 1)) idx = '0;
      else                      idx = idx + IW'(1);
      if (!found && vld[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  // A locked owner is the only candidate; otherwise search starts after the pointer.
  always_comb begin
    w_win     = 1'b0;
    w_win_idx = r_owner;
    if (r_lock) begin
      w_win     = req_valid_i[r_owner];
      w_win_idx = r_owner;
    end else begin
      {w_win, w_win_idx} = f_rr_pick(req_valid_i, r_ptr);
    end
  end

  assign w_go      = tx_ready_i & w_win;
  assign w_cnt_hit = (r_cnt == TO_WIDTH'(BUSY_TIMEOUT - 1));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_START;
        else      w_state_nxt = S_IDLE;
      end
      S_START: begin
        if (!tx_ready_i)    w_state_nxt = S_WAIT_DONE;
        else if (w_cnt_hit) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_START;
      end
      S_WAIT_DONE: begin
        if (tx_ready_i) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_WAIT_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    w_lock_nxt     = r_lock;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last;
    w_ack_nxt      = '0;
    w_grant_nxt    = r_grant;
    w_tx_start_nxt = r_tx_start;
    w_tx_data_nxt  = r_tx_data;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_owner_nxt    = w_win_idx;
          w_tx_data_nxt  = req_data_i[{w_win_idx, 3'b000} +: 8];
          w_last_nxt     = req_last_i[w_win_idx];
          w_grant_nxt    = f_onehot(w_win_idx);
          w_ack_nxt      = f_onehot(w_win_idx);
          w_tx_start_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else begin
          w_grant_nxt = r_lock ? f_onehot(r_owner) : '0;
        end
      end
      S_START: begin
        if (!tx_ready_i) begin
          w_tx_start_nxt = 1'b0;
        end else if (w_cnt_hit) begin
          // The byte is dropped: the requester already saw its ack.
          w_tx_start_nxt = 1'b0;
          w_timeout_nxt  = 1'b1;
          w_lock_nxt     = 1'b0;
          w_grant_nxt    = '0;
          w_ptr_nxt      = r_owner;
        end else begin
          w_cnt_nxt = r_cnt + TO_WIDTH'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready_i) begin
          if (r_last) begin
            w_lock_nxt  = 1'b0;
            w_ptr_nxt   = r_owner;
            w_grant_nxt = '0;
          end else begin
            w_lock_nxt = 1'b1;
          end
        end else begin
          w_lock_nxt = r_lock;
        end
      end
      default: begin
        w_lock_nxt     = 1'b0;
        w_grant_nxt    = '0;
        w_tx_start_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lock     <= 1'b0;
      r_ptr      <= IW'(NREQ - 1);
      r_owner    <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_ack      <= '0;
      r_grant    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock     <= w_lock_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
      r_ack      <= w_ack_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign req_ack_o  = r_ack;
  assign grant_o    = r_grant;
  assign tx_start_o = r_tx_start;
  assign tx_data_o  = r_tx_data;
  assign busy_o     = r_busy;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a transaction-level
// reference model of arbitration, packet locking, handshake and timeout.
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int BT   = 16;
  localparam int TOW  = 4;
  localparam int DW   = 8 * NREQ;
  localparam int QD   = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid_i;
  logic [DW-1:0]   req_data_i;
  logic [NREQ-1:0] req_last_i;
  logic [NREQ-1:0] req_ack_o;
  logic [NREQ-1:0] grant_o;
  logic            tx_start_o;
  logic [7:0]      tx_data_o;
  logic            tx_ready_i;
  logic            busy_o;
  logic            timeout_o;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT), .TO_WIDTH(TOW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ack_o(req_ack_o), .grant_o(grant_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Per-requester byte queues {last, data}, keyed by requester*QD + position.
  logic [8:0] qmem [int];
  int         hd   [int];
  int         tl   [int];

  // Reference model state.
  int              m_rr, m_owner, m_phase, m_cnt;
  bit              m_lock, m_last;
  logic [NREQ-1:0] e_ack, e_grant;
  logic            e_start, e_busy, e_to;
  logic [7:0]      e_data;

  // Stimulus and observation state.
  int   tx_mode, tx_hold, tx_busy;
  bit   drop_en;
  int   cyc, run_len, last_run;
  logic prev_start;
  int   ev_req[$];
  int   ev_dat[$];
  int   rise_q[$];
  int   to_q[$];

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int j);
    return ((v >> j) & NREQ'(1)) != '0;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    ev_req.delete(); ev_dat.delete(); rise_q.delete(); to_q.delete();
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    qmem[r*QD + tl[r]] = {last, d};
    tl[r]++;
  endtask

  task automatic model_reset();
    m_rr = NREQ - 1; m_owner = 0; m_phase = 0; m_cnt = 0;
    m_lock = 1'b0; m_last = 1'b0;
    e_ack = '0; e_grant = '0; e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_data = 8'h00;
  endtask

  // Phases: 0 = free, 1 = byte offered to transmitter, 2 = transmitter sending.
  task automatic model_step(input logic [NREQ-1:0] vld, input logic rdy);
    int w;
    w     = -1;
    e_ack = '0;
    e_to  = 1'b0;
    if (m_phase == 0) begin
      if (rdy) begin
        if (m_lock) begin
          if (bit_of(vld, m_owner)) w = m_owner;
        end else begin
          for (int k = 1; k <= NREQ; k++)
            if (w < 0 && bit_of(vld, (m_rr + k) % NREQ)) w = (m_rr + k) % NREQ;
        end
      end
      if (w >= 0) begin
        e_data  = qmem[w*QD + hd[w]][7:0];
        m_last  = qmem[w*QD + hd[w]][8];
        hd[w]++;
        m_owner = w;
        e_grant = NREQ'(1) << w;
        e_ack   = NREQ'(1) << w;
        e_start = 1'b1;
        m_cnt   = 0;
        m_phase = 1;
      end else begin
        e_grant = m_lock ? (NREQ'(1) << m_owner) : '0;
      end
    end else if (m_phase == 1) begin
      if (!rdy) begin
        e_start = 1'b0;
        m_phase = 2;
      end else if (m_cnt == BT - 1) begin
        e_start = 1'b0; e_to = 1'b1; m_lock = 1'b0; e_grant = '0; m_rr = m_owner; m_phase = 0;
      end else begin
        m_cnt++;
      end
    end else if (rdy) begin
      m_phase = 0;
      if (m_last) begin
        m_lock = 1'b0; m_rr = m_owner; e_grant = '0;
      end else begin
        m_lock = 1'b1;
      end
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic cycle(input bit do_rst);
    logic [NREQ-1:0] v, l;
    logic [DW-1:0]   d;
    logic            rdy;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hd[i] < tl[i]) begin
        if (!drop_en || $urandom_range(0, 3) != 0) v |= NREQ'(1) << i;
        d |= DW'(qmem[i*QD + hd[i]][7:0]) << (8*i);
        l |= NREQ'(qmem[i*QD + hd[i]][8]) << i;
      end else begin
        d |= DW'($urandom_range(0, 255)) << (8*i);
      end
    end
    // Transmitter: mode 0 random, 1 busy 10 cycles, 2 stuck ready, 3 ready held 5 cycles.
    if (tx_busy > 0) begin
      rdy = 1'b0;
      tx_busy--;
    end else if (tx_mode == 2) begin
      rdy = 1'b1;
    end else if (tx_start_o) begin
      if (tx_hold > 0) begin
        rdy = 1'b1;
        tx_hold--;
      end else begin
        rdy     = 1'b0;
        tx_busy = (tx_mode == 0) ? $urandom_range(0, 9) : 9;
        tx_hold = (tx_mode == 0) ? $urandom_range(0, 5) : ((tx_mode == 3) ? 5 : 0);
      end
    end else begin
      rdy = (tx_mode == 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
    rst = do_rst; req_valid_i = v; req_data_i = d; req_last_i = l; tx_ready_i = rdy;
    if (do_rst) model_reset();
    else        model_step(v, rdy);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("ack",      32'(req_ack_o),  32'(e_ack));
    check("grant",    32'(grant_o),    32'(e_grant));
    check("tx_start", 32'(tx_start_o), 32'(e_start));
    check("tx_data",  32'(tx_data_o),  32'(e_data));
    check("busy",     32'(busy_o),     32'(e_busy));
    check("timeout",  32'(timeout_o),  32'(e_to));
    for (int i = 0; i < NREQ; i++)
      if (bit_of(req_ack_o, i)) begin
        ev_req.push_back(i);
        ev_dat.push_back(int'(tx_data_o));
      end
    if (tx_start_o && !prev_start) rise_q.push_back(cyc);
    if (timeout_o) to_q.push_back(cyc);
    if (tx_start_o) run_len++;
    else if (prev_start) begin
      last_run = run_len;
      run_len  = 0;
    end
    prev_start = tx_start_o;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle(1'b0);
      done = (m_phase == 0);
      for (int i = 0; i < NREQ; i++) if (hd[i] < tl[i]) done = 1'b0;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic restart(input int mode);
    clear_all();
    tx_mode = mode; tx_busy = 0; tx_hold = (mode == 3) ? 5 : 0;
    cycle(1'b1);
  endtask

  initial begin
    int exp_rr[6];
    int exp_lr[7];
    int exp_ld[7];
    int stuck_left;
    exp_rr = '{0, 1, 2, 0, 1, 2};
    exp_lr = '{0, 1, 1, 1, 1, 2, 0};
    exp_ld = '{'h10, 'h41, 'h42, 'h43, 'h44, 'h30, 'h11};
    cyc = 0; run_len = 0; last_run = 0; prev_start = 1'b0; drop_en = 1'b0;
    tx_mode = 1; tx_hold = 0; tx_busy = 0;
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_ready_i = 1'b1;
    clear_all();
    model_reset();

    // Reset with every requester valid, then plain round-robin.
    for (int i = 0; i < NREQ; i++) begin
      push_byte(i, 8'(8'hA0 + i), 1'b1);
      push_byte(i, 8'(8'hB0 + i), 1'b1);
    end
    for (int n = 0; n < 3; n++) cycle(1'b1);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_start", 32'(tx_start_o), 32'd0);
    drain("rr_drain", 400);
    check("rr_count", 32'(ev_req.size()), 32'd6);
    for (int k = 0; k < 6 && k < ev_req.size(); k++) check("rr_order", 32'(ev_req[k]), 32'(exp_rr[k]));

    // Packet lock keeps requester 1 despite others being valid.
    restart(1);
    push_byte(0, 8'h10, 1'b1); push_byte(0, 8'h11, 1'b1);
    push_byte(1, 8'h41, 1'b0); push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b0); push_byte(1, 8'h44, 1'b1);
    push_byte(2, 8'h30, 1'b1);
    drain("lock_drain", 400);
    check("lock_count", 32'(ev_req.size()), 32'd7);
    for (int k = 0; k < 7 && k < ev_req.size(); k++) begin
      check("lock_req",  32'(ev_req[k]), 32'(exp_lr[k]));
      check("lock_data", 32'(ev_dat[k]), 32'(exp_ld[k]));
    end

    // Transmitter keeps ready high 5 cycles after start.
    restart(3);
    push_byte(2, 8'h5A, 1'b1);
    drain("hs_drain", 100);
    check("hs_req", 32'(ev_req.size() > 0 ? ev_req[0] : -1), 32'd2);
    check("hs_start_len", 32'(last_run), 32'(1 + 5));

    // Stuck transmitter: timeout then next requester is served.
    restart(2);
    push_byte(0, 8'h77, 1'b1);
    push_byte(1, 8'h78, 1'b1);
    drain("to_drain", 200);
    check("to_count", 32'(to_q.size()), 32'd2);
    if (to_q.size() > 0 && rise_q.size() > 0)
      check("to_delay", 32'(to_q[0] - rise_q[0]), 32'(BT));
    else
      check("to_seen", 32'(to_q.size() * rise_q.size()), 32'd1);
    check("to_next", 32'(ev_req.size() > 1 ? ev_req[1] : -1), 32'd1);

    // Reset while the transmitter sends the second byte of a locked packet.
    restart(1);
    push_byte(1, 8'h51, 1'b0); push_byte(1, 8'h52, 1'b0); push_byte(1, 8'h53, 1'b1);
    for (int n = 0; n < 100 && !(ev_req.size() == 2 && m_phase == 2); n++) cycle(1'b0);
    check("mr_reached", 32'(ev_req.size() == 2 && m_phase == 2), 32'd1);
    push_byte(0, 8'h0A, 1'b1); push_byte(2, 8'h0C, 1'b1);
    ev_req.delete(); ev_dat.delete();
    cycle(1'b1);
    check("mr_grant", 32'(grant_o), 32'd0);
    check("mr_start", 32'(tx_start_o), 32'd0);
    drain("mr_drain", 400);
    check("mr_first",      32'(ev_req.size() > 0 ? ev_req[0] : -1), 32'd0);
    check("mr_first_data", 32'(ev_dat.size() > 0 ? ev_dat[0] : -1), 32'h0A);

    // Random traffic with valid drops, stuck windows and occasional resets.
    restart(0);
    drop_en = 1'b1;
    stuck_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (hd[i] == tl[i] && tl[i] < QD - 8 && $urandom_range(0, 5) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
        end
      if (stuck_left > 0) begin
        stuck_left--;
        if (stuck_left == 0) tx_mode = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        tx_mode = 2;
        stuck_left = 40;
      end
      cycle($urandom_range(0, 499) == 0);
    end
    tx_mode = 0;
    drain("rand_drain", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
